kbd_state_table: RTL and testbench
==================================

KBD_STATE_TABLE -- requirements
Module: kbd_state_table

Interface
REQ-001 Parameter NUM_RD, default 2, number of independent key-state read ports (1..8).
REQ-002 Parameter FIFO_DEPTH, default 8, event FIFO entries, power of two, 2..64.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 byte_in  input  8  received PS/2 set-2 byte from ps2_in.
REQ-006 byte_valid  input  1  one-cycle strobe qualifying byte_in.
REQ-007 clear_all  input  1  synchronous clear of key table and overflow flag.
REQ-008 rd_addr  input  NUM_RD*9  per-port key index {ext, code[7:0]}.
REQ-009 rd_pressed  output  NUM_RD  per-port registered key state.
REQ-010 shift  output  1  left (0x012) or right (0x059) shift held.
REQ-011 any_pressed  output  1  at least one table bit set.
REQ-012 evt_data  output  10  {brk, ext, code[7:0]} at FIFO head.
REQ-013 evt_valid  output  1  FIFO non-empty.
REQ-014 evt_ready  input  1  consumer pop; pop occurs when evt_valid && evt_ready.
REQ-015 evt_overflow  output  1  sticky, an event was dropped.

Function
REQ-016 Key table SHALL be 512 bits indexed {ext, code}; a completed make sets the bit, a completed break clears it.
REQ-017 Decoder FSM SHALL have states IDLE, BRK, EXT, EXT_BRK, PAUSE, advancing only on byte_valid.
REQ-018 IDLE: 0xF0->BRK; 0xE0->EXT; 0xE1->PAUSE; other byte->make ext=0, stay IDLE.
REQ-019 EXT: 0xF0->EXT_BRK; other byte->make ext=1, ->IDLE; BRK and EXT_BRK: byte->break with ext 0/1, ->IDLE.
REQ-020 PAUSE SHALL discard exactly 7 further bytes via a 3-bit counter, then post event {0,1,0xE1} without touching the table, ->IDLE.
REQ-021 Table update SHALL occur on the clock edge that samples the completing byte; event SHALL appear at evt_valid one cycle later.
REQ-022 A make for an already-set bit (typematic repeat) SHALL NOT post an event; a break for an already-clear bit SHALL NOT post an event.
REQ-023 Push to a full FIFO SHALL drop the new event and set evt_overflow; simultaneous push and pop when full SHALL accept the push.
REQ-024 rd_pressed SHALL have 1-cycle latency; same-cycle table write and read SHALL return the pre-write value.
REQ-025 shift and any_pressed SHALL be registered, reflecting the table one cycle after update.
REQ-026 clear_all SHALL zero the table and evt_overflow and return the FSM to IDLE; clear_all coincident with a completing byte SHALL win (no update, no event); FIFO contents SHALL be retained.

Reset
REQ-027 rst SHALL asynchronously force table=0, FSM=IDLE, pause counter=0, FIFO empty, evt_overflow=0, rd_pressed=0, shift=0, any_pressed=0.
REQ-028 Reset asserted mid-sequence (e.g., after 0xE0) SHALL discard the partial sequence.

Configuration
REQ-029 Macro KBD_EVENT_FIFO_EN defined: event FIFO and REQ-012..015,022,023 as specified.
REQ-030 Macro undefined: no FIFO storage; evt_valid, evt_data, evt_overflow tied 0; evt_ready ignored; table behaviour unchanged.

Structure
REQ-031 Shared package kbd_pkg SHALL hold FSM state encoding, prefix constants 0xE0/0xF0/0xE1, shift codes, index width 9, event width 10.
REQ-032 FIFO SHALL be sub-module kbd_event_fifo (parameter DEPTH, WIDTH), instantiated only under KBD_EVENT_FIFO_EN.

Verification
REQ-033 Bytes 0x1C -> bit 0x01C=1, event {0,0,0x1C}; then 0xF0,0x1C -> bit=0, event {1,0,0x1C}.
REQ-034 Bytes 0xE0,0x75 then 0xE0,0xF0,0x75 -> bit 0x175 set then clear; events ext=1; bit 0x075 untouched.
REQ-035 0x1C sent 5 times -> exactly one event; any_pressed=1.
REQ-036 Pause 0xE1,0x14,0x77,0xE1,0xF0,0x14,0xF0,0x77 -> one event {0,1,0xE1}; table unchanged; FSM back in IDLE.
REQ-037 evt_ready=0, FIFO_DEPTH+1 distinct makes -> FIFO_DEPTH events held, evt_overflow=1; clear_all -> overflow=0, FIFO kept.
REQ-038 0x12 then rst pulse after a lone 0xF0 -> shift=0, table zero; next 0x12 -> make, shift=1.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared PS/2 set-2 decoder definitions: FSM states, prefix bytes, key codes and widths.
package kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK,
        ST_PAUSE
    } kbd_state_e;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;

    localparam int IDX_W = 9;
    localparam int EVT_W = 10;

    localparam logic [IDX_W-1:0] KEY_LSHIFT = 9'h012;
    localparam logic [IDX_W-1:0] KEY_RSHIFT = 9'h059;

    // Pause is E1 followed by seven bytes; the counter value on the last one.
    localparam logic [2:0] PAUSE_LAST = 3'd6;

    function automatic logic [EVT_W-1:0] pack_evt(input logic brk, input logic [IDX_W-1:0] idx);
        return {brk, idx};
    endfunction

endpackage

// File: rtl/kbd_state_table_if.sv
// Byte-input, key-state read and event-stream bundle of kbd_state_table.
interface kbd_state_table_if
    import kbd_pkg::*;
#(
    parameter int NUM_RD = 2
) ();

    logic [7:0]              byte_in;
    logic                    byte_valid;
    logic                    clear_all;
    logic [NUM_RD*IDX_W-1:0] rd_addr;
    logic [NUM_RD-1:0]       rd_pressed;
    logic                    shift;
    logic                    any_pressed;
    logic [EVT_W-1:0]        evt_data;
    logic                    evt_valid;
    logic                    evt_ready;
    logic                    evt_overflow;

    modport master (
        output byte_in, byte_valid, clear_all, rd_addr, evt_ready,
        input  rd_pressed, shift, any_pressed, evt_data, evt_valid, evt_overflow
    );

    modport slave (
        input  byte_in, byte_valid, clear_all, rd_addr, evt_ready,
        output rd_pressed, shift, any_pressed, evt_data, evt_valid, evt_overflow
    );

endinterface

// File: rtl/kbd_event_fifo.sv
// Synchronous FWFT FIFO for key events; a push while full is accepted only with a pop.
module kbd_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage carries data only; occupancy lives in the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/kbd_state_table.sv
// PS/2 set-2 key-state table with decoder FSM, registered read ports and status.
// Optional event FIFO enabled by defining KBD_EVENT_FIFO_EN.
module kbd_state_table
    import kbd_pkg::*;
#(
    parameter int NUM_RD     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input logic                clk,
    input logic                rst,
    kbd_state_table_if.slave   bus
);

    kbd_state_e        state_q;
    logic [2:0]        pause_cnt_q;
    logic [511:0]      key_tbl_q;

    logic              key_done;
    logic              key_brk;
    logic [IDX_W-1:0]  key_idx;
    logic              pause_done;

    logic [NUM_RD-1:0] rd_pressed_p1;
    logic              shift_p1;
    logic              any_p1;

    // Decode whether the byte on this cycle completes a key sequence.
    always_comb begin
        key_done   = 1'b0;
        key_brk    = 1'b0;
        key_idx    = {1'b0, bus.byte_in};
        pause_done = 1'b0;
        if (bus.byte_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    key_done = (bus.byte_in != PFX_BRK) && (bus.byte_in != PFX_EXT) &&
                               (bus.byte_in != PFX_PAUSE);
                end
                ST_EXT: begin
                    key_done = (bus.byte_in != PFX_BRK);
                    key_idx  = {1'b1, bus.byte_in};
                end
                ST_BRK: begin
                    key_done = 1'b1;
                    key_brk  = 1'b1;
                end
                ST_EXT_BRK: begin
                    key_done = 1'b1;
                    key_brk  = 1'b1;
                    key_idx  = {1'b1, bus.byte_in};
                end
                ST_PAUSE: begin
                    pause_done = (pause_cnt_q == PAUSE_LAST);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pause_cnt_q <= '0;
            key_tbl_q   <= '0;
        end else if (bus.clear_all) begin
            state_q     <= ST_IDLE;
            pause_cnt_q <= '0;
            key_tbl_q   <= '0;
        end else if (bus.byte_valid) begin
            if (key_done) key_tbl_q[key_idx] <= ~key_brk;
            unique case (state_q)
                ST_IDLE: begin
                    case (bus.byte_in)
                        PFX_BRK:   state_q <= ST_BRK;
                        PFX_EXT:   state_q <= ST_EXT;
                        PFX_PAUSE: begin
                            state_q     <= ST_PAUSE;
                            pause_cnt_q <= '0;
                        end
                        default:   state_q <= ST_IDLE;
                    endcase
                end
                ST_EXT:     state_q <= (bus.byte_in == PFX_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK,
                ST_EXT_BRK: state_q <= ST_IDLE;
                ST_PAUSE: begin
                    if (pause_done) begin
                        state_q     <= ST_IDLE;
                        pause_cnt_q <= '0;
                    end else begin
                        pause_cnt_q <= pause_cnt_q + 3'd1;
                    end
                end
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // ---- stage p1: registered views of the pre-update table ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pressed_p1 <= '0;
            shift_p1      <= 1'b0;
            any_p1        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_pressed_p1[i] <= key_tbl_q[bus.rd_addr[i*IDX_W +: IDX_W]];
            end
            shift_p1 <= key_tbl_q[KEY_LSHIFT] | key_tbl_q[KEY_RSHIFT];
            any_p1   <= |key_tbl_q;
        end
    end

    assign bus.rd_pressed  = rd_pressed_p1;
    assign bus.shift       = shift_p1;
    assign bus.any_pressed = any_p1;

`ifdef KBD_EVENT_FIFO_EN
    logic             evt_push;
    logic [EVT_W-1:0] evt_word;
    logic             evt_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [EVT_W-1:0] fifo_dout;
    logic             ovf_q;

    // Typematic repeats and redundant breaks change nothing, so they post nothing.
    assign evt_push = !bus.clear_all &&
                      (pause_done || (key_done && (key_tbl_q[key_idx] == key_brk)));
    assign evt_word = pause_done ? pack_evt(1'b0, {1'b1, PFX_PAUSE}) : pack_evt(key_brk, key_idx);
    assign evt_pop  = bus.evt_ready && !fifo_empty;

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt_push),
        .din   (evt_word),
        .pop   (evt_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.clear_all) begin
            ovf_q <= 1'b0;
        end else if (evt_push && fifo_full && !evt_pop) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.evt_data     = fifo_dout;
    assign bus.evt_valid    = !fifo_empty;
    assign bus.evt_overflow = ovf_q;
`else
    assign bus.evt_data     = '0;
    assign bus.evt_valid    = 1'b0;
    assign bus.evt_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_state_table.sv
// Scoreboard bench for kbd_state_table: sequence-level reference model, directed and random bytes.
module tb_kbd_state_table;
    import kbd_pkg::*;

    localparam int NUM_RD = 2;
    localparam int DEPTH  = 4;
`ifdef KBD_EVENT_FIFO_EN
    localparam bit FIFO_ON = 1'b1;
`else
    localparam bit FIFO_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kbd_state_table_if #(.NUM_RD(NUM_RD)) bus ();

    kbd_state_table #(.NUM_RD(NUM_RD), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: key table as a bit per key, pending bytes of an unfinished sequence.
    bit               tbl [512];
    logic [7:0]       pend [$];
    int               cnt;
    logic [9:0]       exp_q [$];
    bit               exp_shift, exp_any, exp_ovf;
    logic [NUM_RD-1:0] exp_rd;
    int               n_seen = 0;
    logic [9:0]       last_evt = '0;

    bit               cur_rdy = 1'b1;
    logic [NUM_RD*9-1:0] cur_ra = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        foreach (tbl[k]) tbl[k] = 1'b0;
        pend.delete();
        exp_q.delete();
        cnt = 0;
        exp_shift = 1'b0;
        exp_any = 1'b0;
        exp_ovf = 1'b0;
        exp_rd = '0;
    endtask

    // Applies the effect of the clock edge that just sampled the current inputs.
    task automatic model_edge();
        bit         pop, post, done, brk, anyb;
        logic [8:0] idx;
        logic [9:0] ev;
        if (rst) begin
            model_reset();
            return;
        end
        anyb = 1'b0;
        foreach (tbl[k]) anyb |= tbl[k];
        exp_shift = tbl[9'h012] | tbl[9'h059];
        exp_any = anyb;
        for (int i = 0; i < NUM_RD; i++) exp_rd[i] = tbl[bus.rd_addr[i*9 +: 9]];
        pop = bus.evt_ready && (cnt > 0);
        post = 1'b0; done = 1'b0; brk = 1'b0; idx = '0; ev = '0;
        if (bus.clear_all) begin
            foreach (tbl[k]) tbl[k] = 1'b0;
            pend.delete();
            exp_ovf = 1'b0;
        end else if (bus.byte_valid) begin
            pend.push_back(bus.byte_in);
            if (pend[0] == 8'hE1) begin
                if (pend.size() == 8) begin
                    post = 1'b1;
                    ev = {2'b01, 8'hE1};
                    pend.delete();
                end
            end else if (pend[0] == 8'hE0) begin
                if (pend.size() == 2 && pend[1] != 8'hF0) begin
                    done = 1'b1; idx = {1'b1, pend[1]};
                end else if (pend.size() == 3) begin
                    done = 1'b1; brk = 1'b1; idx = {1'b1, pend[2]};
                end
            end else if (pend[0] == 8'hF0) begin
                if (pend.size() == 2) begin
                    done = 1'b1; brk = 1'b1; idx = {1'b0, pend[1]};
                end
            end else begin
                done = 1'b1; idx = {1'b0, pend[0]};
            end
            if (done) begin
                post = (tbl[idx] == brk);
                ev = {brk, idx};
                tbl[idx] = !brk;
                pend.delete();
            end
        end
        if (FIFO_ON && post) begin
            if (cnt < DEPTH || pop) begin
                exp_q.push_back(ev);
                cnt++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        if (FIFO_ON && pop) cnt--;
    endtask

    task automatic step(input bit bv, input logic [7:0] b, input bit clr);
        @(posedge clk);
        #1;
        model_edge();
        bus.byte_valid = bv;
        bus.byte_in    = b;
        bus.clear_all  = clr;
        bus.evt_ready  = cur_rdy;
        bus.rd_addr    = cur_ra;
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        model_edge();
        bus.byte_valid = 1'b0;
        bus.clear_all  = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        model_edge();
        rst = 1'b0;
    endtask

    // Monitor: compares every cycle, pops the scoreboard on each consumed event.
    always @(negedge clk) begin
        chk("rd_pressed", 32'(bus.rd_pressed), 32'(exp_rd));
        chk("shift", 32'(bus.shift), 32'(exp_shift));
        chk("any_pressed", 32'(bus.any_pressed), 32'(exp_any));
`ifdef KBD_EVENT_FIFO_EN
        chk("evt_valid", 32'(bus.evt_valid), 32'(cnt > 0));
        chk("evt_overflow", 32'(bus.evt_overflow), 32'(exp_ovf));
        if (bus.evt_valid && bus.evt_ready) begin
            n_seen++;
            last_evt = bus.evt_data;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL evt_unexpected actual=%0h required=none", bus.evt_data);
            end else begin
                chk("evt_data", 32'(bus.evt_data), 32'(exp_q.pop_front()));
            end
        end
`else
        chk("evt_tied_off", {20'd0, bus.evt_valid, bus.evt_overflow, bus.evt_data}, 32'd0);
`endif
    end

    logic [7:0] pool [12] = '{8'h12, 8'h59, 8'h1C, 8'h75, 8'h14, 8'h77,
                              8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h1C, 8'hE1};
    logic [8:0] keys [6] = '{9'h012, 9'h059, 9'h01C, 9'h175, 9'h075, 9'h014};

    initial begin
        int base;
        bus.byte_in = '0;
        bus.byte_valid = 1'b0;
        bus.clear_all = 1'b0;
        bus.rd_addr = '0;
        bus.evt_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_any", 32'(bus.any_pressed), 32'd0);
        chk("reset_evt_valid", 32'(bus.evt_valid), 32'd0);
        @(posedge clk);
        #1;
        model_edge();
        rst = 1'b0;

        // Plain make then break of 0x1C
        cur_ra = {9'h175, 9'h01C};
        idle(1);
        send(8'h1C); idle(2);
        @(negedge clk) chk("make_1c", 32'(bus.rd_pressed[0]), 32'd1);
        send(8'hF0); send(8'h1C); idle(2);
        @(negedge clk) chk("break_1c", 32'(bus.rd_pressed[0]), 32'd0);

        // Extended key 0x175 does not alias 0x075
        cur_ra = {9'h175, 9'h075};
        send(8'hE0); send(8'h75); idle(2);
        @(negedge clk);
        chk("ext_make", 32'(bus.rd_pressed[1]), 32'd1);
        chk("ext_alias", 32'(bus.rd_pressed[0]), 32'd0);
        send(8'hE0); send(8'hF0); send(8'h75); idle(2);
        @(negedge clk) chk("ext_break", 32'(bus.rd_pressed[1]), 32'd0);

        // Typematic repeat posts one event
        base = n_seen;
        repeat (5) send(8'h1C);
        idle(3);
        @(negedge clk);
        chk("repeat_any", 32'(bus.any_pressed), 32'd1);
`ifdef KBD_EVENT_FIFO_EN
        chk("repeat_events", 32'(n_seen - base), 32'd1);
`endif
        send(8'hF0); send(8'h1C);

        // Pause sequence
        cur_ra = {9'h077, 9'h014};
        base = n_seen;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        idle(3);
        @(negedge clk);
        chk("pause_tbl", 32'(bus.rd_pressed), 32'd0);
`ifdef KBD_EVENT_FIFO_EN
        chk("pause_events", 32'(n_seen - base), 32'd1);
        chk("pause_evt", 32'(last_evt), 32'h1E1);
`endif
        send(8'h14); idle(2);
        @(negedge clk) chk("after_pause_idle", 32'(bus.rd_pressed[0]), 32'd1);

        // Overflow with a stalled consumer
        step(1'b0, 8'h00, 1'b1);
        cur_rdy = 1'b0;
        base = n_seen;
        for (int i = 0; i <= DEPTH; i++) send(8'h20 + 8'(i));
        idle(2);
        @(negedge clk);
`ifdef KBD_EVENT_FIFO_EN
        chk("ovf_set", 32'(bus.evt_overflow), 32'd1);
        chk("ovf_valid", 32'(bus.evt_valid), 32'd1);
`endif
        step(1'b0, 8'h00, 1'b1);
        idle(1);
        @(negedge clk);
`ifdef KBD_EVENT_FIFO_EN
        chk("ovf_cleared", 32'(bus.evt_overflow), 32'd0);
        chk("ovf_fifo_kept", 32'(bus.evt_valid), 32'd1);
`endif
        cur_rdy = 1'b1;
        idle(DEPTH + 2);
`ifdef KBD_EVENT_FIFO_EN
        chk("ovf_held_events", 32'(n_seen - base), 32'(DEPTH));
`endif

        // Reset in the middle of a break sequence
        send(8'h12); idle(2);
        @(negedge clk) chk("shift_on", 32'(bus.shift), 32'd1);
        send(8'hF0);
        reset_pulse();
        @(negedge clk);
        chk("rst_shift", 32'(bus.shift), 32'd0);
        chk("rst_any", 32'(bus.any_pressed), 32'd0);
        send(8'h12); idle(2);
        @(negedge clk) chk("shift_after_rst", 32'(bus.shift), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 1200; n++) begin
            cur_rdy = ($urandom_range(0, 3) != 0);
            cur_ra = {keys[$urandom_range(0, 5)], keys[$urandom_range(0, 5)]};
            if (n == 600) reset_pulse();
            step(1'(($urandom_range(0, 2) != 0)), pool[$urandom_range(0, 11)],
                 1'(($urandom_range(0, 79) == 0)));
        end
        cur_rdy = 1'b1;
        idle(DEPTH + 4);
        @(negedge clk);
`ifdef KBD_EVENT_FIFO_EN
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
